// File: rtl/rv_pipe_pkg.sv
// rv_pipe_pkg: shared instruction-class, bank and latency definitions for the issue scoreboard
package rv_pipe_pkg;
  typedef enum logic [1:0] {
    CLS_ALU  = 2'b00,
    CLS_LOAD = 2'b01,
    CLS_MUL  = 2'b10,
    CLS_FPU  = 2'b11
  } iclass_e;
  typedef enum logic {
    BANK_GPR = 1'b0,
    BANK_FPR = 1'b1
  } bank_e;
  localparam int LAT_ALU      = 1;
  localparam int LAT_LOAD_DEF = 2;
  localparam int LAT_MUL_DEF  = 3;
  localparam int LAT_FPU_DEF  = 4;
  localparam int MAX_LAT_DEF  = 8;
  function automatic int class_lat(input iclass_e c, input int ll, input int lm, input int lf);
    return c == CLS_ALU ? LAT_ALU : c == CLS_LOAD ? ll : c == CLS_MUL ? lm : lf;
  endfunction
endpackage

// File: rtl/sb_countdown.sv
// sb_countdown: one register's cycles-until-forwardable countdown; a load overrides the decrement
module sb_countdown #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         active_d
);
  logic [W-1:0] cnt_d, cnt_q;
  always_comb begin
    cnt_d = load ? load_val : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
  end
  assign active_d = cnt_d != '0;
  assign cnt      = cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
endmodule

// File: rtl/pipeline_scoreboard.sv
// pipeline_scoreboard: RAW/WAW/writeback-port interlock for issue, with per-register countdowns
module pipeline_scoreboard
  import rv_pipe_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int LAT_LOAD = LAT_LOAD_DEF,
  parameter int LAT_MUL  = LAT_MUL_DEF,
  parameter int LAT_FPU  = LAT_FPU_DEF,
  parameter int MAX_LAT  = MAX_LAT_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        issue_valid,
  input  logic [$clog2(NUM_REGS)-1:0] issue_rs1,
  input  logic [$clog2(NUM_REGS)-1:0] issue_rs2,
  input  logic                        issue_rs1_bank,
  input  logic                        issue_rs2_bank,
  input  logic                        issue_rd_bank,
  input  logic                        issue_rs1_used,
  input  logic                        issue_rs2_used,
  input  logic [$clog2(NUM_REGS)-1:0] issue_rd,
  input  logic                        issue_we,
  input  logic [1:0]                  issue_class,
  input  logic                        flush,
  output logic                        issue_ready,
  output logic                        busy,
  output logic [31:0]                 stall_cycles
);
  localparam int IW = $clog2(NUM_REGS);
  localparam int CW = $clog2(MAX_LAT + 1);

  if (LAT_LOAD < 1 || LAT_LOAD > MAX_LAT || LAT_MUL < 1 || LAT_MUL > MAX_LAT ||
      LAT_FPU < 1 || LAT_FPU > MAX_LAT) begin : g_lat_check
    $fatal(1, "pipeline_scoreboard: every latency must lie in 1..MAX_LAT");
  end

  logic [CW-1:0]         cnt [2][NUM_REGS];
  logic [2*NUM_REGS-1:0] act_d;
  logic [CW-1:0]         lat, lat_m1;
  logic                  raw, waw, port, fire, rd_live, load_en;
  logic [MAX_LAT:1]      slot_q, slot_post, slot_d;
  logic [31:0]           stall_q, stall_d;
  logic                  busy_q, busy_d;

  // All hazard checks look at pre-update state; slot check uses the post-shift position
  always_comb begin
    lat         = CW'(class_lat(iclass_e'(issue_class), LAT_LOAD, LAT_MUL, LAT_FPU));
    lat_m1      = lat - 1'b1;
    raw         = (issue_rs1_used && cnt[issue_rs1_bank][issue_rs1] != '0) ||
                  (issue_rs2_used && cnt[issue_rs2_bank][issue_rs2] != '0);
    waw         = issue_we && cnt[issue_rd_bank][issue_rd] > lat_m1;
    slot_post   = slot_q >> 1;
    port        = issue_we && slot_post[lat];
    issue_ready = !issue_valid || !(raw || waw || port);
    fire        = issue_valid && issue_ready && !flush;
    rd_live     = issue_we && !(issue_rd_bank == BANK_GPR && issue_rd == '0);
    load_en     = fire && rd_live;
    slot_d      = slot_post | (load_en ? MAX_LAT'(1) << lat_m1 : '0);
    stall_d     = (issue_valid && !issue_ready && stall_q != '1) ? stall_q + 32'd1 : stall_q;
    busy_d      = (|slot_d) || (|act_d);
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
      sb_countdown #(.W(CW)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (load_en && issue_rd_bank == 1'(b) && issue_rd == IW'(r)),
        .load_val (lat_m1),
        .cnt      (cnt[b][r]),
        .active_d (act_d[b*NUM_REGS+r])
      );
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q  <= '0;
      stall_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      stall_q <= stall_d;
      busy_q  <= busy_d;
    end
  end

  assign busy         = busy_q;
  assign stall_cycles = stall_q;
endmodule

// File: tb/tb_pipeline_scoreboard.sv
// tb_pipeline_scoreboard: directed issue sequences with queued expectations checked by a negedge monitor
module tb_pipeline_scoreboard;
  import rv_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid, issue_rs1_bank, issue_rs2_bank, issue_rd_bank;
  logic        issue_rs1_used, issue_rs2_used, issue_we, flush;
  logic [4:0]  issue_rs1, issue_rs2, issue_rd;
  logic [1:0]  issue_class;
  logic        issue_ready, busy;
  logic [31:0] stall_cycles;

  typedef struct {
    logic v; logic [1:0] cls;
    logic [4:0] rs1; logic b1; logic u1;
    logic [4:0] rs2; logic b2; logic u2;
    logic [4:0] rd; logic bd; logic we; logic fl;
  } ins_t;

  typedef struct {
    string nm; int er; int eb; int es;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipeline_scoreboard dut (
    .clk            (clk),
    .rst            (rst),
    .issue_valid    (issue_valid),
    .issue_rs1      (issue_rs1),
    .issue_rs2      (issue_rs2),
    .issue_rs1_bank (issue_rs1_bank),
    .issue_rs2_bank (issue_rs2_bank),
    .issue_rd_bank  (issue_rd_bank),
    .issue_rs1_used (issue_rs1_used),
    .issue_rs2_used (issue_rs2_used),
    .issue_rd       (issue_rd),
    .issue_we       (issue_we),
    .issue_class    (issue_class),
    .flush          (flush),
    .issue_ready    (issue_ready),
    .busy           (busy),
    .stall_cycles   (stall_cycles)
  );

  function automatic void chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  function automatic ins_t mk(input logic [1:0] c, input logic [4:0] s1, input logic b1, input logic u1,
                              input logic [4:0] s2, input logic b2, input logic u2,
                              input logic [4:0] d, input logic bd, input logic we, input logic fl);
    ins_t i;
    i.v = 1'b1; i.cls = c;
    i.rs1 = s1; i.b1 = b1; i.u1 = u1;
    i.rs2 = s2; i.b2 = b2; i.u2 = u2;
    i.rd = d; i.bd = bd; i.we = we; i.fl = fl;
    return i;
  endfunction

  function automatic ins_t nop();
    ins_t i;
    i = mk(2'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    i.v = 1'b0;
    return i;
  endfunction

  task automatic drive(input ins_t i);
    issue_valid = i.v; issue_class = i.cls;
    issue_rs1 = i.rs1; issue_rs1_bank = i.b1; issue_rs1_used = i.u1;
    issue_rs2 = i.rs2; issue_rs2_bank = i.b2; issue_rs2_used = i.u2;
    issue_rd = i.rd; issue_rd_bank = i.bd; issue_we = i.we; flush = i.fl;
  endtask

  // Expected values apply to the negedge of the cycle whose inputs are driven here
  task automatic step(input ins_t i, input int er, input int eb, input int es, input string nm);
    @(posedge clk);
    #1;
    drive(i);
    q.push_back(exp_t'{nm, er, eb, es});
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    drive(nop());
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      e = q.pop_front();
      if (e.er >= 0) chk({e.nm, " issue_ready"}, int'(issue_ready), e.er);
      if (e.eb >= 0) chk({e.nm, " busy"}, int'(busy), e.eb);
      if (e.es >= 0) chk({e.nm, " stall_cycles"}, int'(stall_cycles), e.es);
    end
  end

  ins_t a1, b1, r, w;

  initial begin
    drive(nop());
    do_reset();
    // LOAD x5 then ALU consumer of x5
    a1 = mk(CLS_ALU, 5'd5, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd6, 1'b0, 1'b1, 1'b0);
    step(mk(CLS_LOAD, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b0, 1'b1, 1'b0), 1, 0, 0, "A0");
    step(a1, 0, 1, 0, "A1");
    step(a1, 1, 1, 1, "A2");
    step(nop(), 1, 1, 1, "A3");
    step(nop(), 1, 0, 1, "A4");
    // FPU f3 then FPU consumer of f3, bank separation, then consumer of f4
    do_reset();
    b1 = mk(CLS_FPU, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0);
    step(mk(CLS_FPU, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b1, 1'b0), 1, 0, 0, "B0");
    step(b1, 0, 1, 0, "B1");
    step(b1, 0, 1, 1, "B2");
    step(b1, 0, 1, 2, "B3");
    step(b1, 1, 1, 3, "B4");
    step(mk(CLS_ALU, 5'd3, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0), 1, 1, 3, "B5");
    step(mk(CLS_ALU, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0), 0, 1, 3, "B6");
    step(nop(), 1, 1, 4, "B7");
    // MUL x7 and ALU x9 collide on the writeback port
    do_reset();
    step(mk(CLS_MUL, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b0, 1'b1, 1'b0), 1, 0, 0, "C0");
    step(nop(), 1, 1, 0, "C1");
    w = mk(CLS_ALU, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b0, 1'b1, 1'b0);
    step(w, 0, 1, 0, "C2");
    step(w, 1, 1, 1, "C3");
    step(nop(), 1, 1, 1, "C4");
    // x0 is never reserved, f0 is
    do_reset();
    step(mk(CLS_ALU, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0), 1, 0, 0, "D0");
    step(mk(CLS_ALU, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0), 1, 0, 0, "D1");
    step(mk(CLS_LOAD, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0), 1, 0, 0, "D2");
    step(mk(CLS_ALU, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0), 1, 0, 0, "D3");
    step(mk(CLS_FPU, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0), 1, 0, 0, "D4");
    step(mk(CLS_ALU, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0), 0, 1, 0, "D5");
    step(nop(), 1, 1, 1, "D6");
    // flushed MUL x4 reserves nothing; pending LOAD x2 keeps counting down
    do_reset();
    step(mk(CLS_LOAD, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd2, 1'b0, 1'b1, 1'b0), 1, 0, 0, "E0");
    step(mk(CLS_MUL, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b0, 1'b1, 1'b1), 1, 1, 0, "E1");
    step(mk(CLS_ALU, 5'd4, 1'b0, 1'b1, 5'd2, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0), 1, 1, 0, "E2");
    step(nop(), 1, 0, 0, "E3");
    // asynchronous reset while an FPU reservation is at 2
    do_reset();
    r = mk(CLS_FPU, 5'd1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    step(mk(CLS_FPU, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd1, 1'b1, 1'b1, 1'b0), 1, 0, 0, "F0");
    step(r, 0, 1, 0, "F1");
    step(r, 0, 1, 1, "F2");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("F rst issue_ready", int'(issue_ready), 1);
    chk("F rst busy", int'(busy), 0);
    chk("F rst stall_cycles", int'(stall_cycles), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(r, 1, 0, 0, "F3");
    // WAW on f5, then writeback-port conflict on f6
    do_reset();
    step(mk(CLS_FPU, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0), 1, 0, 0, "G0");
    w = mk(CLS_ALU, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    step(w, 0, 1, 0, "G1");
    step(w, 0, 1, 1, "G2");
    w = mk(CLS_ALU, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
    step(w, 0, 1, 2, "G3");
    step(w, 1, 1, 3, "G4");
    step(nop(), -1, -1, -1, "end");
    repeat (3) @(posedge clk);
    chk("queue drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_scoreboard.md
PIPELINE_SCOREBOARD -- requirements
Module: pipeline_scoreboard

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, registers per bank.
REQ-002 SHALL have parameter LAT_LOAD, default 2, load issue-to-forwardable cycles.
REQ-003 SHALL have parameter LAT_MUL, default 3, MUL issue-to-forwardable cycles.
REQ-004 SHALL have parameter LAT_FPU, default 4, FPU issue-to-forwardable cycles.
REQ-005 SHALL have parameter MAX_LAT, default 8, counter and slot-vector depth; elaboration fails if any LAT_* exceeds MAX_LAT or is below 1.
REQ-006 SHALL have one clock and an asynchronous active-high reset: clk  in  1  clock; rst  in  1  reset.
REQ-007 issue_valid  in  1  decode holds an instruction requesting issue to execute.
REQ-008 issue_rs1, issue_rs2  in  clog2(NUM_REGS) each  source register indices.
REQ-009 issue_rs1_bank, issue_rs2_bank, issue_rd_bank  in  1 each  0 = GPR, 1 = FPR.
REQ-010 issue_rs1_used, issue_rs2_used  in  1 each  source is actually read.
REQ-011 issue_rd  in  clog2(NUM_REGS)  destination index.
REQ-012 issue_we  in  1  instruction writes rd.
REQ-013 issue_class  in  2  00 ALU (latency 1), 01 LOAD, 10 MUL, 11 FPU.
REQ-014 flush  in  1  branch/jump taken in execute this cycle.
REQ-015 issue_ready  out  1  combinational; low means stall decode.
REQ-016 busy  out  1  registered; any counter non-zero or any slot occupied.
REQ-017 stall_cycles  out  32  registered saturating count of cycles with issue_valid & !issue_ready.

Function
REQ-018 Per bank and register, a countdown cnt[bank][r] of width clog2(MAX_LAT+1) SHALL be kept; GPR x0 is never set, FPR f0 is tracked.
REQ-019 issue_fire = issue_valid & issue_ready & !flush; flush suppresses the same-cycle issue only and never clears existing counters.
REQ-020 On issue_fire with issue_we (and not GPR x0), cnt[rd_bank][rd] SHALL be loaded with L-1, L being the class latency; the consumer may then issue no earlier than L cycles after the producer.
REQ-021 Every non-zero counter not being loaded SHALL decrement by 1 per cycle; a load in the same cycle overrides the decrement.
REQ-022 RAW stall: issue_ready low if a used source has cnt != 0; checks use pre-update counter values.
REQ-023 WAW stall: issue_ready low if issue_we and cnt[rd_bank][rd] > L-1 of the new instruction.
REQ-024 Writeback-port stall: slot vector wb_slot[MAX_LAT:1] SHALL shift toward 1 each cycle; issue_fire sets bit L; issue_ready low if issue_we and wb_slot[L] (post-shift position) is already set.
REQ-025 issue_ready SHALL be high whenever issue_valid is low.
REQ-026 stall_cycles SHALL saturate at 32'hFFFF_FFFF, not wrap.
REQ-027 No other state machine; all state is counters, slot vector, perf counter.

Reset
REQ-028 rst asserted SHALL asynchronously clear all cnt, wb_slot, stall_cycles, and busy to 0.
REQ-029 During rst issue_ready SHALL follow REQ-022..025 on cleared state (high); reset mid-operation discards all pending reservations.

Structure
REQ-030 Class encodings, LAT_* defaults, and bank encodings SHALL live in shared package rv_pipe_pkg.
REQ-031 One sub-module, sb_countdown (single register countdown with load/decrement), SHALL be instantiated 2*NUM_REGS times.

Verification
REQ-032 LOAD to x5 issued cycle 0, ALU reading x5 valid cycle 1 -> issue_ready 0 at cycle 1, 1 at cycle 2; stall_cycles = 1.
REQ-033 FPU to f3 at cycle 0, FPU reading f3 from cycle 1 -> stalled cycles 1-3, fires cycle 4; stall_cycles = 3.
REQ-034 MUL to x7 cycle 0, ALU writing x9 cycle 2 (both slot 1 at cycle 3) -> issue_ready 0 at cycle 2, 1 at cycle 3.
REQ-035 ALU write to x0 followed by reads of x0 -> never stalls; busy stays 0.
REQ-036 flush with issue_valid for MUL to x4 -> no reservation, next reader of x4 not stalled; earlier pending LOAD counter still decrements.
REQ-037 rst asserted mid-FPU reservation (cnt = 2) -> all counters 0 immediately, busy 0, stall_cycles 0.
